// File: rtl/shift_reg_sipo_rx.sv
// Serial-in parallel-out receiver: MSB-first bits on sdi (strobed by sdi_en) assembled into WIDTH-bit words.
// Latency: the edge that samples a word's last bit also loads dout/dout_valid, visible the following cycle.
// Backpressure: one-word holding register; a completed word that finds it occupied and not drained is dropped, setting sticky overrun.
module shift_reg_sipo_rx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sdi,
  input  logic             sdi_en,
  input  logic             sync,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             clr_overrun
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_sh;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dout;
  logic             r_valid;
  logic             r_overrun;

  logic [WIDTH-1:0] w_word;
  logic             w_complete;
  logic             w_accept;
  logic             w_load;
  logic             w_drop;

  // Word assembly and the load/drop decision; sync outranks completion on the last bit.
  always_comb begin
    w_word     = {r_sh[WIDTH-2:0], sdi};
    w_complete = sdi_en && !sync && (r_cnt == LAST_BIT);
    w_accept   = r_valid && dout_ready;
    w_load     = w_complete && (!r_valid || dout_ready);
    w_drop     = w_complete && r_valid && !dout_ready;
  end

  // Shift register and bit counter advance only on strobed bits; sync restarts the count at 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (sdi_en) begin
      r_sh <= w_word;
      if (sync) begin
        r_cnt <= CW'(1);
      end else if (r_cnt == LAST_BIT) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Holding register: new word loads (even on the same edge as an accept), otherwise accept empties it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_dout  <= w_word;
      r_valid <= 1'b1;
    end else if (w_accept) begin
      r_valid <= 1'b0;
    end
  end

  // Sticky overrun: a drop on the same edge as a clear keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (clr_overrun) begin
      r_overrun <= 1'b0;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign overrun    = r_overrun;
  assign busy       = (r_cnt != '0);

endmodule

// File: tb/tb_shift_reg_sipo_rx.sv
// Bench for shift_reg_sipo_rx (WIDTH=4): vector table, hand-written reset sequence, scoreboarded stream.
// Inputs change on the falling edge; outputs are compared on the following falling edge.
// Stream words are queued when their last bit is driven and popped when dout_valid appears.
module tb_shift_reg_sipo_rx;

  logic       clk;
  logic       reset_n;
  logic       sdi;
  logic       sdi_en;
  logic       sync;
  logic [3:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       busy;
  logic       overrun;
  logic       clr_overrun;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       en;
    logic       d;
    logic       sy;
    logic       rdy;
    logic       clr;
    logic [3:0] e_dout;
    logic       e_vld;
    logic       e_busy;
    logic       e_ovr;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] sb[$];

  shift_reg_sipo_rx #(.WIDTH(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sdi         (sdi),
    .sdi_en      (sdi_en),
    .sync        (sync),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .busy        (busy),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic d, input logic sy, input logic rdy, input logic clr,
                     input logic [3:0] e_dout, input logic e_vld, input logic e_busy, input logic e_ovr);
    vec_t v;
    v.en = en; v.d = d; v.sy = sy; v.rdy = rdy; v.clr = clr;
    v.e_dout = e_dout; v.e_vld = e_vld; v.e_busy = e_busy; v.e_ovr = e_ovr;
    vecs.push_back(v);
  endtask

  // Called just after a falling edge: apply inputs, let one rising edge pass, return at the next falling edge.
  task automatic drive(input logic en, input logic d, input logic sy, input logic rdy, input logic clr);
    sdi_en = en; sdi = d; sync = sy; dout_ready = rdy; clr_overrun = clr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all(input string tag, input logic [3:0] e_dout, input logic e_vld,
                           input logic e_busy, input logic e_ovr);
    chk({tag, ".dout"},       32'(dout),       32'(e_dout));
    chk({tag, ".dout_valid"}, 32'(dout_valid), 32'(e_vld));
    chk({tag, ".busy"},       32'(busy),       32'(e_busy));
    chk({tag, ".overrun"},    32'(overrun),    32'(e_ovr));
  endtask

  // One stream cycle with dout_ready high; any valid word must match the oldest queued word.
  task automatic step_sb(input logic en, input logic d);
    logic [3:0] w;
    drive(en, d, 1'b0, 1'b1, 1'b0);
    if (dout_valid) begin
      if (sb.size() == 0) begin
        chk("stream.unexpected_word", 32'(dout), 32'hFFFF_FFFF);
      end else begin
        w = sb.pop_front();
        chk("stream.word", 32'(dout), 32'(w));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] w;
    reset_n = 1'b0; sdi = 1'b0; sdi_en = 1'b0; sync = 1'b0; dout_ready = 1'b0; clr_overrun = 1'b0;

    // Basic receive 1011
    add(1,1,0,1,0, 4'h0,0,1,0);
    add(1,0,0,1,0, 4'h0,0,1,0);
    add(1,1,0,1,0, 4'h0,0,1,0);
    add(1,1,0,1,0, 4'hB,1,0,0);
    add(0,0,0,1,0, 4'hB,0,0,0);
    // Gapped strobes, idle sdi values must not enter the word
    add(1,1,0,1,0, 4'hB,0,1,0);
    add(0,0,0,1,0, 4'hB,0,1,0);
    add(1,0,0,1,0, 4'hB,0,1,0);
    add(0,1,0,1,0, 4'hB,0,1,0);
    add(1,1,0,1,0, 4'hB,0,1,0);
    add(0,0,0,1,0, 4'hB,0,1,0);
    add(1,1,0,1,0, 4'hB,1,0,0);
    add(0,0,0,1,0, 4'hB,0,0,0);
    // Back-to-back A then 5, ready raised on the edge the 5 completes
    add(1,1,0,0,0, 4'hB,0,1,0);
    add(1,0,0,0,0, 4'hB,0,1,0);
    add(1,1,0,0,0, 4'hB,0,1,0);
    add(1,0,0,0,0, 4'hA,1,0,0);
    add(1,0,0,0,0, 4'hA,1,1,0);
    add(1,1,0,0,0, 4'hA,1,1,0);
    add(1,0,0,0,0, 4'hA,1,1,0);
    add(1,1,0,1,0, 4'h5,1,0,0);
    add(0,0,0,1,0, 4'h5,0,0,0);
    // Overrun: 3 held, C dropped, third word dropped with clear on same edge, then clear alone
    add(1,0,0,0,0, 4'h5,0,1,0);
    add(1,0,0,0,0, 4'h5,0,1,0);
    add(1,1,0,0,0, 4'h5,0,1,0);
    add(1,1,0,0,0, 4'h3,1,0,0);
    add(1,1,0,0,0, 4'h3,1,1,0);
    add(1,1,0,0,0, 4'h3,1,1,0);
    add(1,0,0,0,0, 4'h3,1,1,0);
    add(1,0,0,0,0, 4'h3,1,0,1);
    add(1,0,0,0,0, 4'h3,1,1,1);
    add(1,1,0,0,0, 4'h3,1,1,1);
    add(1,0,0,0,0, 4'h3,1,1,1);
    add(1,1,0,0,1, 4'h3,1,0,1);
    add(0,0,0,0,1, 4'h3,1,0,0);
    add(0,0,0,1,0, 4'h3,0,0,0);
    // Sync after 2 bits, new word 1100
    add(1,1,0,1,0, 4'h3,0,1,0);
    add(1,0,0,1,0, 4'h3,0,1,0);
    add(1,1,1,1,0, 4'h3,0,1,0);
    add(1,1,0,1,0, 4'h3,0,1,0);
    add(1,0,0,1,0, 4'h3,0,1,0);
    add(1,0,0,1,0, 4'hC,1,0,0);
    add(0,0,0,1,0, 4'hC,0,0,0);
    // Sync on the 4th bit: no word, restart; word becomes 0110
    add(1,1,0,1,0, 4'hC,0,1,0);
    add(1,1,0,1,0, 4'hC,0,1,0);
    add(1,1,0,1,0, 4'hC,0,1,0);
    add(1,0,1,1,0, 4'hC,0,1,0);
    add(1,1,0,1,0, 4'hC,0,1,0);
    add(1,1,0,1,0, 4'hC,0,1,0);
    add(1,0,0,1,0, 4'h6,1,0,0);
    add(0,0,0,1,0, 4'h6,0,0,0);
    // Unstrobed sync is ignored
    add(0,1,1,1,0, 4'h6,0,0,0);
    add(1,1,0,1,0, 4'h6,0,1,0);

    repeat (2) @(negedge clk);
    check_all("reset", 4'h0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].d, vecs[i].sy, vecs[i].rdy, vecs[i].clr);
      check_all($sformatf("vec%0d", i), vecs[i].e_dout, vecs[i].e_vld, vecs[i].e_busy, vecs[i].e_ovr);
    end

    // Finish word 1001 (first bit already in), drop 0110, then two bits of a partial word
    drive(1,0,0,0,0); drive(1,0,0,0,0); drive(1,1,0,0,0);
    check_all("pre_rst.word", 4'h9, 1'b1, 1'b0, 1'b0);
    drive(1,0,0,0,0); drive(1,1,0,0,0); drive(1,1,0,0,0); drive(1,0,0,0,0);
    drive(1,1,0,0,0); drive(1,1,0,0,0);
    check_all("pre_rst.partial", 4'h9, 1'b1, 1'b1, 1'b1);
    #2 reset_n = 1'b0;
    #1 check_all("async_rst", 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(1,0,0,1,0); drive(1,1,0,1,0); drive(1,1,0,1,0); drive(1,1,0,1,0);
    check_all("post_rst.word", 4'h7, 1'b1, 1'b0, 1'b0);
    drive(0,0,0,1,0);
    chk("post_rst.drain", 32'(dout_valid), 32'd0);

    // Scoreboarded stream with random gaps, ready held high
    for (int n = 0; n < 24; n++) begin
      w = 4'($urandom_range(0, 15));
      for (int b = 3; b >= 0; b--) begin
        if ($urandom_range(0, 2) == 0) step_sb(1'b0, 1'($urandom_range(0, 1)));
        if (b == 0) sb.push_back(w);
        step_sb(1'b1, w[b]);
      end
    end
    for (int k = 0; k < 8 && sb.size() != 0; k++) step_sb(1'b0, 1'b0);
    chk("stream.leftover", 32'(sb.size()), 32'd0);
    chk("stream.overrun", 32'(overrun), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
